// File: rtl/cpu_pkg.sv
// Shared ALU definitions: opcodes, flag layout, FSM states and iterative-unit mode.
package cpu_pkg;

  localparam int unsigned ALU_WIDTH   = 16;
  localparam int unsigned ALU_SHAMT_W = 4;
  localparam int unsigned ALU_OP_W    = 6;
  localparam int unsigned ALU_CODE_W  = 5;

  localparam logic [ALU_OP_W-1:0] ALU_CODE_MASK = 6'b01_1111;

  localparam logic [ALU_CODE_W-1:0] OP_ADD = 5'b01011;
  localparam logic [ALU_CODE_W-1:0] OP_SUB = 5'b01100;
  localparam logic [ALU_CODE_W-1:0] OP_LSR = 5'b01101;
  localparam logic [ALU_CODE_W-1:0] OP_LSL = 5'b01110;
  localparam logic [ALU_CODE_W-1:0] OP_RSR = 5'b01111;
  localparam logic [ALU_CODE_W-1:0] OP_RSL = 5'b10000;
  localparam logic [ALU_CODE_W-1:0] OP_MUL = 5'b10001;
  localparam logic [ALU_CODE_W-1:0] OP_DIV = 5'b10010;
  localparam logic [ALU_CODE_W-1:0] OP_MOD = 5'b10011;
  localparam logic [ALU_CODE_W-1:0] OP_AND = 5'b10100;
  localparam logic [ALU_CODE_W-1:0] OP_OR  = 5'b10101;
  localparam logic [ALU_CODE_W-1:0] OP_XOR = 5'b10110;
  localparam logic [ALU_CODE_W-1:0] OP_NOT = 5'b10111;
  localparam logic [ALU_CODE_W-1:0] OP_MOV = 5'b11000;
  localparam logic [ALU_CODE_W-1:0] OP_CMP = 5'b11001;
  localparam logic [ALU_CODE_W-1:0] OP_TST = 5'b11010;
  localparam logic [ALU_CODE_W-1:0] OP_INC = 5'b11011;
  localparam logic [ALU_CODE_W-1:0] OP_DEC = 5'b11100;

  localparam int unsigned ZF = 3;
  localparam int unsigned NF = 2;
  localparam int unsigned CF = 1;
  localparam int unsigned VF = 0;

  // Field order matches ZF..VF bit indices
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [2:0] {IDLE, EXEC, ITER, FINAL, DONE} alu_state_t;

  typedef enum logic {MD_MUL, MD_DIV} md_mode_t;

  function automatic logic is_iter_op(input logic [ALU_CODE_W-1:0] code);
    return (code == OP_MUL) || (code == OP_DIV) || (code == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Control-unit <-> ALU request/response handshake.
interface alu_exec_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
);
  logic                start;
  logic [ALU_OP_W-1:0] alu_operation;
  logic [WIDTH-1:0]    op1;
  logic [WIDTH-1:0]    op2;
  logic                done;
  logic [WIDTH-1:0]    result;
  alu_flags_t          flags;

  modport master (output start, alu_operation, op1, op2, input done, result, flags);
  modport slave  (input start, alu_operation, op1, op2, output done, result, flags);
endinterface

// File: rtl/alu_iter_muldiv.sv
// WIDTH-step unsigned shift-add multiplier / restoring divider sharing one hi:lo register pair.
module alu_iter_muldiv
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  md_mode_t         mode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             last_c
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;
  md_mode_t         mode_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH:0]   add_sum, rem_sh, rem_sub;

  // One step: multiply adds into hi and shifts right; divide shifts left and trial-subtracts
  always_comb begin
    add_sum = {1'b0, hi_q} + {1'b0, b_q};
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, b_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (mode_q == MD_MUL) begin
      if (lo_q[0]) {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
      else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end else if (!rem_sub[WIDTH]) begin
      hi_d = rem_sub[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_d = rem_sh[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      mode_q <= MD_MUL;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
    end else if (load) begin
      cnt    <= CNT_W'(WIDTH);
      mode_q <= mode;
      hi_q   <= '0;
      lo_q   <= opa;
      b_q    <= opb;
    end else if (cnt != '0) begin
      cnt  <= cnt - CNT_W'(1);
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign prod_hi   = hi_q;
  assign prod_lo   = lo_q;
  assign quotient  = lo_q;
  assign remainder = hi_q;
  assign busy      = (cnt != '0);
  assign last_c    = (cnt == CNT_W'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// ALU responder: latches operands on start, executes single-cycle or iterative ops, holds result/flags.
module alu_exec_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
  input logic            clk,
  input logic            reset,
  alu_exec_unit_if.slave bus
);
  localparam int unsigned MSB = WIDTH - 1;

  alu_state_t             state;
  logic [ALU_CODE_W-1:0]  op_q;
  logic [WIDTH-1:0]       a_q, b_q;
  logic                   done_q;
  logic [WIDTH-1:0]       result_q;
  alu_flags_t             flags_q;

  logic [ALU_CODE_W-1:0]  op_code;
  logic                   md_load;
  md_mode_t               md_mode;
  logic [WIDTH-1:0]       md_hi, md_lo, md_quo, md_rem;
  logic                   md_busy, md_last_c;

  // Opcode bit 5 (immediate select) is resolved upstream and masked off here
  assign op_code = ALU_CODE_W'(bus.alu_operation & ALU_CODE_MASK);
  assign md_load = (state == IDLE) && bus.start && is_iter_op(op_code) && (bus.op2 != '0);
  assign md_mode = (op_code == OP_MUL) ? MD_MUL : MD_DIV;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .load      (md_load),
    .mode      (md_mode),
    .opa       (bus.op1),
    .opb       (bus.op2),
    .prod_hi   (md_hi),
    .prod_lo   (md_lo),
    .quotient  (md_quo),
    .remainder (md_rem),
    .busy      (md_busy),
    .last_c    (md_last_c)
  );

  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     add_b;
  logic [WIDTH:0]       sum_ext, dif_ext, shl_ext, shr_ext;
  logic [2*WIDTH-1:0]   rot_r, rot_l;
  logic [WIDTH-1:0]     exec_res;
  logic                 exec_c, exec_v, exec_zn;
  alu_flags_t           exec_flags;

  assign shamt = b_q[SHAMT_W-1:0];

  // Single-cycle datapath on latched operands; also covers MUL/DIV/MOD with a zero divisor
  always_comb begin
    add_b    = ((op_q == OP_INC) || (op_q == OP_DEC)) ? WIDTH'(1) : b_q;
    sum_ext  = {1'b0, a_q} + {1'b0, add_b};
    dif_ext  = {1'b0, a_q} - {1'b0, add_b};
    shl_ext  = {1'b0, a_q} << shamt;
    shr_ext  = {a_q, 1'b0} >> shamt;
    rot_r    = {a_q, a_q} >> shamt;
    rot_l    = {a_q, a_q} << shamt;
    exec_res = '0;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
    exec_zn  = 1'b1;
    case (op_q)
      OP_ADD, OP_INC: begin
        exec_res = sum_ext[WIDTH-1:0];
        exec_c   = sum_ext[WIDTH];
        exec_v   = (a_q[MSB] == add_b[MSB]) && (exec_res[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        exec_res = dif_ext[WIDTH-1:0];
        exec_c   = ~dif_ext[WIDTH];
        exec_v   = (a_q[MSB] != add_b[MSB]) && (exec_res[MSB] != a_q[MSB]);
      end
      OP_LSR: begin
        exec_res = shr_ext[WIDTH:1];
        exec_c   = shr_ext[0];
      end
      OP_LSL: begin
        exec_res = shl_ext[WIDTH-1:0];
        exec_c   = shl_ext[WIDTH];
      end
      OP_RSR: begin
        exec_res = rot_r[WIDTH-1:0];
        exec_c   = (shamt != '0) && exec_res[MSB];
      end
      OP_RSL: begin
        exec_res = rot_l[2*WIDTH-1:WIDTH];
        exec_c   = (shamt != '0) && exec_res[0];
      end
      OP_MUL: exec_res = '0;
      OP_DIV: begin
        exec_res = '1;
        exec_v   = 1'b1;
      end
      OP_MOD: begin
        exec_res = a_q;
        exec_v   = 1'b1;
      end
      OP_AND, OP_TST: exec_res = a_q & b_q;
      OP_OR:          exec_res = a_q | b_q;
      OP_XOR:         exec_res = a_q ^ b_q;
      OP_NOT:         exec_res = ~a_q;
      OP_MOV:         exec_res = b_q;
      default:        exec_zn  = 1'b0;
    endcase
    exec_flags.z = exec_zn && (exec_res == '0);
    exec_flags.n = exec_zn && exec_res[MSB];
    exec_flags.c = exec_c;
    exec_flags.v = exec_v;
  end

  logic [WIDTH-1:0] fin_res;
  logic             fin_c;
  alu_flags_t       fin_flags;

  // Pack iterative results; only MUL/DIV/MOD can reach FINAL
  always_comb begin
    fin_res = md_lo;
    fin_c   = (md_hi != '0);
    case (op_q)
      OP_DIV: begin
        fin_res = md_quo;
        fin_c   = 1'b0;
      end
      OP_MOD: begin
        fin_res = md_rem;
        fin_c   = 1'b0;
      end
      default: ;
    endcase
    fin_flags.z = (fin_res == '0);
    fin_flags.n = fin_res[MSB];
    fin_flags.c = fin_c;
    fin_flags.v = fin_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q  <= op_code;
            a_q   <= bus.op1;
            b_q   <= bus.op2;
            state <= md_load ? ITER : EXEC;
          end
        end
        EXEC: begin
          result_q <= exec_res;
          flags_q  <= exec_flags;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        ITER: begin
          if (md_last_c || !md_busy) state <= FINAL;
        end
        FINAL: begin
          result_q <= fin_res;
          flags_q  <= fin_flags;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (!bus.start) begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Table-driven and scoreboard-checked bench for alu_exec_unit.
module tb_alu_exec_unit;

  localparam logic [5:0] T_ADD = 6'b001011, T_SUB = 6'b001100, T_LSR = 6'b001101;
  localparam logic [5:0] T_LSL = 6'b001110, T_RSR = 6'b001111, T_RSL = 6'b010000;
  localparam logic [5:0] T_MUL = 6'b010001, T_DIV = 6'b010010, T_MOD = 6'b010011;
  localparam logic [5:0] T_AND = 6'b010100, T_OR  = 6'b010101, T_XOR = 6'b010110;
  localparam logic [5:0] T_NOT = 6'b010111, T_MOV = 6'b011000, T_CMP = 6'b011001;
  localparam logic [5:0] T_TST = 6'b011010, T_INC = 6'b011011, T_DEC = 6'b011100;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  vec_t sb_q[$];

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(16)) bus ();

  alu_exec_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [5:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] res,
                              input logic [3:0] flg, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.res = res; v.flg = flg; v.lat = lat;
    return v;
  endfunction

  // Reference model for the randomised ops (b is nonzero)
  function automatic vec_t model(input int sel, input logic [15:0] a, input logic [15:0] b);
    vec_t v;
    int   sa, sb, sr;
    logic [31:0] p;
    logic c, ov;
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; ov = 1'b0; v.lat = 2;
    case (sel)
      0: begin v.op = T_ADD; v.res = a + b; sr = sa + sb;
               c = (int'(a) + int'(b)) > 65535; ov = (sr > 32767) || (sr < -32768); end
      1: begin v.op = T_SUB; v.res = a - b; sr = sa - sb;
               c = (a >= b); ov = (sr > 32767) || (sr < -32768); end
      2: begin v.op = T_MUL; p = {16'h0, a} * {16'h0, b}; v.res = p[15:0];
               c = (p[31:16] != 16'h0); ov = c; v.lat = 18; end
      3: begin v.op = T_DIV; v.res = a / b; v.lat = 18; end
      4: begin v.op = T_MOD; v.res = a % b; v.lat = 18; end
      default: begin v.op = T_XOR; v.res = a ^ b; end
    endcase
    v.name = $sformatf("rnd_op%0d_%h_%h", sel, a, b);
    v.a = a; v.b = b;
    v.flg = {v.res == 16'h0, v.res[15], c, ov};
    return v;
  endfunction

  // Issue one op with start held until done, then release and confirm done falls
  task automatic do_op(input vec_t v);
    int          k;
    vec_t        e;
    logic [3:0]  f;
    logic [15:0] r;
    @(negedge clk);
    bus.start = 1'b1; bus.alu_operation = v.op; bus.op1 = v.a; bus.op2 = v.b;
    sb_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    bus.op1 = 16'($urandom); bus.op2 = 16'($urandom); bus.alu_operation = 6'($urandom);
    k = 0;
    while (bus.done !== 1'b1 && k < 40) begin
      @(posedge clk); k++; @(negedge clk);
    end
    e = sb_q.pop_front();
    check({e.name, " done_seen"}, 32'(bus.done), 32'd1);
    check({e.name, " latency"}, 32'(k + 1), 32'(e.lat));
    f = bus.flags;
    check({e.name, " result"}, 32'(bus.result), 32'(e.res));
    check({e.name, " flags"}, 32'(f), 32'(e.flg));
    r = bus.result;
    @(posedge clk); @(negedge clk);
    check({e.name, " done_held"}, 32'(bus.done), 32'd1);
    check({e.name, " result_held"}, 32'(bus.result), 32'(r));
    bus.start = 1'b0;
    @(posedge clk); @(negedge clk);
    check({e.name, " done_drop"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, limit 1000000 ns");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk("add_ovf",   T_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 2));
    vecs.push_back(mk("add_carry", T_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 2));
    vecs.push_back(mk("cmp_eq",    T_CMP, 16'h0005, 16'h0005, 16'h0000, 4'b1010, 2));
    vecs.push_back(mk("sub_neg",   T_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100, 2));
    vecs.push_back(mk("mul_hi",    T_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b1011, 18));
    vecs.push_back(mk("mul_small", T_MUL, 16'h0007, 16'h0006, 16'h002A, 4'b0000, 18));
    vecs.push_back(mk("mul_max",   T_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0011, 18));
    vecs.push_back(mk("mul_zero",  T_MUL, 16'h1234, 16'h0000, 16'h0000, 4'b1000, 2));
    vecs.push_back(mk("div",       T_DIV, 16'd100,  16'd7,    16'h000E, 4'b0000, 18));
    vecs.push_back(mk("mod",       T_MOD, 16'd100,  16'd7,    16'h0002, 4'b0000, 18));
    vecs.push_back(mk("div_small", T_DIV, 16'd5,    16'd7,    16'h0000, 4'b1000, 18));
    vecs.push_back(mk("div_by1",   T_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 4'b0100, 18));
    vecs.push_back(mk("div_zero",  T_DIV, 16'h1234, 16'h0000, 16'hFFFF, 4'b0101, 2));
    vecs.push_back(mk("mod_zero",  T_MOD, 16'h1234, 16'h0000, 16'h1234, 4'b0001, 2));
    vecs.push_back(mk("lsl",       T_LSL, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 2));
    vecs.push_back(mk("lsl_zero",  T_LSL, 16'h1234, 16'h0010, 16'h1234, 4'b0000, 2));
    vecs.push_back(mk("lsr",       T_LSR, 16'h00F8, 16'h0004, 16'h000F, 4'b0010, 2));
    vecs.push_back(mk("rsr",       T_RSR, 16'h0001, 16'h0001, 16'h8000, 4'b0110, 2));
    vecs.push_back(mk("rsl",       T_RSL, 16'h8000, 16'h0001, 16'h0001, 4'b0010, 2));
    vecs.push_back(mk("and",       T_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 2));
    vecs.push_back(mk("or",        T_OR,  16'hF0F0, 16'h0FF0, 16'hFFF0, 4'b0100, 2));
    vecs.push_back(mk("xor",       T_XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 4'b0100, 2));
    vecs.push_back(mk("not",       T_NOT, 16'hFFFF, 16'h1234, 16'h0000, 4'b1000, 2));
    vecs.push_back(mk("mov",       T_MOV, 16'h1234, 16'h8000, 16'h8000, 4'b0100, 2));
    vecs.push_back(mk("tst",       T_TST, 16'h00FF, 16'hFF00, 16'h0000, 4'b1000, 2));
    vecs.push_back(mk("inc_wrap",  T_INC, 16'hFFFF, 16'h1234, 16'h0000, 4'b1010, 2));
    vecs.push_back(mk("inc_ovf",   T_INC, 16'h7FFF, 16'h0000, 16'h8000, 4'b0101, 2));
    vecs.push_back(mk("dec_wrap",  T_DEC, 16'h0000, 16'h5555, 16'hFFFF, 4'b0100, 2));
    vecs.push_back(mk("dec_ovf",   T_DEC, 16'h8000, 16'h0000, 16'h7FFF, 4'b0011, 2));
    vecs.push_back(mk("undef_00",  6'b000000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 2));
    vecs.push_back(mk("undef_1f",  6'b011111, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000, 2));
    vecs.push_back(mk("imm_add",   6'b101011, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 2));
    vecs.push_back(mk("imm_mul",   6'b110001, 16'h0007, 16'h0006, 16'h002A, 4'b0000, 18));

    reset = 1'b1;
    bus.start = 1'b0; bus.alu_operation = '0; bus.op1 = '0; bus.op2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset flags", 32'(bus.flags), 32'd0);

    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i]);

    for (int i = 0; i < 12; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom); rb = 16'($urandom);
      if (rb == 16'h0) rb = 16'h0001;
      do_op(model(i % 6, ra, rb));
    end

    // start pulsed for the accept cycle only: op completes, done lasts one cycle
    @(negedge clk);
    bus.start = 1'b1; bus.alu_operation = T_SUB; bus.op1 = 16'h0003; bus.op2 = 16'h0005;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pulse done", 32'(bus.done), 32'd1);
    check("pulse result", 32'(bus.result), 32'hFFFE);
    check("pulse flags", 32'(bus.flags), 32'b0100);
    @(posedge clk); @(negedge clk);
    check("pulse done_drop", 32'(bus.done), 32'd0);

    // Reset during iteration 5 of a multiply
    do_op(mk("pre_reset_add", T_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 2));
    @(negedge clk);
    bus.start = 1'b1; bus.alu_operation = T_MUL; bus.op1 = 16'h0100; bus.op2 = 16'h0100;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset result", 32'(bus.result), 32'd0);
    check("midreset flags", 32'(bus.flags), 32'd0);
    reset = 1'b0;
    do_op(mk("post_reset_add", T_ADD, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 2));

    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle done", 32'(bus.done), 32'd0);
    check("idle result", 32'(bus.result), 32'h0005);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
